// File: rtl/nfc_tx_bit_serializer.sv
// nfc_tx_bit_serializer
//
// Purpose:
//   Takes bytes from the TX-side stream FIFO and turns them into a timed bit
//   stream for the NFC modulator. Each frame is one SOF bit period, then the
//   data bytes LSB first, then one EOF bit period. Every bit is held for
//   BIT_CYCLES clocks. The frame keeps going while the FIFO has the next byte
//   ready when the last bit of the current byte ends. If no byte is ready at
//   that point, the frame closes with EOF.
//
// Optional feature:
//   NFC_TX_PARITY_EN - when defined, each byte is followed by an odd-parity
//   bit period (PAR state). When undefined, bytes are 8 bit periods long.
//
// Parameters:
//   BIT_CYCLES - clock cycles per bit period (2..65535)
//   CW         - bit-period counter width, 2^CW >= BIT_CYCLES
//
// Ports:
//   clk          - single clock
//   rstn         - asynchronous active-low reset
//   itvalid      - byte available from upstream FIFO
//   itready      - byte accepted this cycle (combinational)
//   itdata       - byte from FIFO, sampled only on handshake
//   tx_en        - high for the whole frame, SOF through EOF
//   tx_bit       - current bit value, stable for the bit period
//   tx_bit_start - one-cycle pulse on the first cycle of every bit period
//   tx_sof       - high during the SOF bit period
//   tx_eof       - high during the EOF bit period
//   byte_cnt     - bytes sent in the current frame, saturates at 255

module nfc_tx_bit_serializer #(
  parameter int BIT_CYCLES = 128,
  parameter int CW         = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       itvalid,
  output logic       itready,
  input  logic [7:0] itdata,
  output logic       tx_en,
  output logic       tx_bit,
  output logic       tx_bit_start,
  output logic       tx_sof,
  output logic       tx_eof,
  output logic [7:0] byte_cnt
);

  localparam logic [CW-1:0] LastCnt = CW'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SOF  = 3'd1,
    DATA = 3'd2,
`ifdef NFC_TX_PARITY_EN
    PAR  = 3'd3,
`endif
    EOF  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byteCnt_q, byteCnt_d;

  logic txEn_q, txEn_d;
  logic txBit_q, txBit_d;
  logic txBitStart_q, txBitStart_d;
  logic txSof_q, txSof_d;
  logic txEof_q, txEof_d;

  logic boundary;
  logic lastBit;

  assign boundary = (state_q != IDLE) && (cnt_q == LastCnt);

  // The last bit of a byte is where the next byte may be pulled in
  // without a gap.
`ifdef NFC_TX_PARITY_EN
  assign lastBit = (state_q == PAR);
`else
  assign lastBit = (state_q == DATA) && (bitIdx_q == 3'd7);
`endif

  assign itready = (state_q == IDLE) || (boundary && lastBit);

  // Next-state logic for the frame FSM, the bit-period counter, the byte
  // being shifted out and the frame byte count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    bitIdx_d  = bitIdx_q;
    shift_d   = shift_q;
    byteCnt_d = byteCnt_q;

    if (state_q != IDLE) begin
      cnt_d = boundary ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (itvalid) begin
          shift_d   = itdata;
          byteCnt_d = '0;
          state_d   = SOF;
        end
      end
      SOF: begin
        if (boundary) begin
          state_d  = DATA;
          bitIdx_d = '0;
        end
      end
      DATA: begin
        if (boundary) begin
          if (bitIdx_q != 3'd7) begin
            bitIdx_d = bitIdx_q + 3'd1;
          end else begin
            if (byteCnt_q != 8'hFF) begin
              byteCnt_d = byteCnt_q + 8'd1;
            end
`ifdef NFC_TX_PARITY_EN
            state_d = PAR;
`else
            // Back-to-back byte goes straight to bit 0; otherwise close the frame.
            if (itvalid) begin
              shift_d  = itdata;
              bitIdx_d = '0;
              state_d  = DATA;
            end else begin
              state_d = EOF;
            end
`endif
          end
        end
      end
`ifdef NFC_TX_PARITY_EN
      PAR: begin
        // Back-to-back byte goes straight to bit 0; otherwise close the frame.
        if (boundary) begin
          if (itvalid) begin
            shift_d  = itdata;
            bitIdx_d = '0;
            state_d  = DATA;
          end else begin
            state_d = EOF;
          end
        end
      end
`endif
      EOF: begin
        if (boundary) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so that they come out of
  // flops and line up with the state they describe.
  always_comb begin
    txEn_d       = (state_d != IDLE);
    txSof_d      = (state_d == SOF);
    txEof_d      = (state_d == EOF);
    txBitStart_d = (state_d != IDLE) && (cnt_d == '0);
    txBit_d      = 1'b0;
    case (state_d)
      DATA:    txBit_d = shift_d[bitIdx_d];
`ifdef NFC_TX_PARITY_EN
      PAR:     txBit_d = ~^shift_d;
`endif
      default: txBit_d = 1'b0;
    endcase
  end

  // State and output registers. Reset drops any frame in progress
  // without emitting EOF.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bitIdx_q     <= '0;
      shift_q      <= '0;
      byteCnt_q    <= '0;
      txEn_q       <= 1'b0;
      txBit_q      <= 1'b0;
      txBitStart_q <= 1'b0;
      txSof_q      <= 1'b0;
      txEof_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bitIdx_q     <= bitIdx_d;
      shift_q      <= shift_d;
      byteCnt_q    <= byteCnt_d;
      txEn_q       <= txEn_d;
      txBit_q      <= txBit_d;
      txBitStart_q <= txBitStart_d;
      txSof_q      <= txSof_d;
      txEof_q      <= txEof_d;
    end
  end

  assign tx_en        = txEn_q;
  assign tx_bit       = txBit_q;
  assign tx_bit_start = txBitStart_q;
  assign tx_sof       = txSof_q;
  assign tx_eof       = txEof_q;
  assign byte_cnt     = byteCnt_q;

endmodule

// File: tb/tb_nfc_tx_bit_serializer.sv
// tb_nfc_tx_bit_serializer
//
// Purpose:
//   Directed bench for nfc_tx_bit_serializer with BIT_CYCLES = 4. It covers
//   a single byte, back-to-back bytes, a byte offered during EOF, a reset in
//   the middle of a frame, and a long frame that saturates byte_cnt. The
//   expected bit periods come from the bench's own frame model.
//   Follows NFC_TX_PARITY_EN the same way the design does.

module tb_nfc_tx_bit_serializer;

  localparam int BC = 4;
`ifdef NFC_TX_PARITY_EN
  localparam int PB = 9;
`else
  localparam int PB = 8;
`endif

  logic       clk;
  logic       rstn;
  logic       itvalid;
  logic       itready;
  logic [7:0] itdata;
  logic       tx_en;
  logic       tx_bit;
  logic       tx_bit_start;
  logic       tx_sof;
  logic       tx_eof;
  logic [7:0] byte_cnt;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] frameBytes [0:299];

  nfc_tx_bit_serializer #(
    .BIT_CYCLES(BC),
    .CW        (16)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .itvalid     (itvalid),
    .itready     (itready),
    .itdata      (itdata),
    .tx_en       (tx_en),
    .tx_bit      (tx_bit),
    .tx_bit_start(tx_bit_start),
    .tx_sof      (tx_sof),
    .tx_eof      (tx_eof),
    .byte_cnt    (byte_cnt)
  );

  // 10 ns clock; inputs are driven and outputs are sampled on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int satCnt(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Checks the outputs of an idle serializer after a frame of n bytes.
  task automatic checkIdle(input int n);
    checkOutput("idle tx_en", 32'(tx_en), 32'd0);
    checkOutput("idle tx_sof", 32'(tx_sof), 32'd0);
    checkOutput("idle tx_eof", 32'(tx_eof), 32'd0);
    checkOutput("idle tx_bit_start", 32'(tx_bit_start), 32'd0);
    checkOutput("idle tx_bit", 32'(tx_bit), 32'd0);
    checkOutput("idle byte_cnt", 32'(byte_cnt), 32'(satCnt(n)));
    checkOutput("idle itready", 32'(itready), 32'd1);
  endtask

  // Offers frameBytes[0..n-1] and checks every cycle of the frame against the
  // model. The caller must be at a falling edge with the DUT idle. The task
  // stops after stopAt checked cycles, or at the end of the frame.
  // offerEof presents offerData during the EOF period.
  task automatic applyStimulus(input int n, input bit offerEof, input logic [7:0] offerData,
                               input int stopAt);
    int nPer;
    int p, c, q, i, j;
    logic eBit, eRdy;
    int eCnt;
    nPer = n * PB + 2;
    itvalid = 1'b1;
    itdata  = frameBytes[0];
    checkOutput("handshake itready", 32'(itready), 32'd1);
    @(posedge clk);
    for (int k = 0; k < nPer * BC && k < stopAt; k++) begin
      @(negedge clk);
      p = k / BC;
      c = k % BC;
      eBit = 1'b0;
      eRdy = 1'b0;
      i = 0;
      if (p == 0) begin
        eCnt = 0;
      end else if (p == nPer - 1) begin
        eCnt = satCnt(n);
        i = n;
      end else begin
        q = p - 1;
        i = q / PB;
        j = q % PB;
        eBit = (j < 8) ? frameBytes[i][j] : ~^frameBytes[i];
        eCnt = satCnt((j >= 8) ? i + 1 : i);
        eRdy = (c == BC - 1) && (j == PB - 1);
      end
      checkOutput("tx_en", 32'(tx_en), 32'd1);
      checkOutput("tx_bit", 32'(tx_bit), 32'(eBit));
      checkOutput("tx_bit_start", 32'(tx_bit_start), 32'(c == 0));
      checkOutput("tx_sof", 32'(tx_sof), 32'(p == 0));
      checkOutput("tx_eof", 32'(tx_eof), 32'(p == nPer - 1));
      checkOutput("byte_cnt", 32'(byte_cnt), 32'(eCnt));
      checkOutput("itready", 32'(itready), 32'(eRdy));
      // Present the next byte the way a FIFO would; garbage when none.
      if (p == nPer - 1) begin
        itvalid = offerEof;
        itdata  = offerEof ? offerData : 8'($urandom);
      end else if (i + 1 < n) begin
        itvalid = 1'b1;
        itdata  = frameBytes[i + 1];
      end else begin
        itvalid = 1'b0;
        itdata  = 8'($urandom);
      end
    end
  endtask

  initial begin
    rstn    = 1'b0;
    itvalid = 1'b0;
    itdata  = 8'h00;

    // Reset values, including itready while reset is held.
    repeat (3) @(negedge clk);
    checkIdle(0);
    rstn = 1'b1;
    @(negedge clk);
    checkIdle(0);

    // Single byte 0x5A.
    $display("[TB] single byte 0x5A");
    frameBytes[0] = 8'h5A;
    applyStimulus(1, 1'b0, 8'h00, 1 << 30);
    @(negedge clk);
    checkIdle(1);

    // Back-to-back 0x00 then 0xFF.
    $display("[TB] back-to-back 0x00, 0xFF");
    frameBytes[0] = 8'h00;
    frameBytes[1] = 8'hFF;
    applyStimulus(2, 1'b0, 8'h00, 1 << 30);
    @(negedge clk);
    checkIdle(2);

    // Byte offered during EOF waits for IDLE, then starts a new frame.
    $display("[TB] byte offered during EOF");
    frameBytes[0] = 8'hA5;
    applyStimulus(1, 1'b1, 8'h3C, 1 << 30);
    @(negedge clk);
    checkIdle(1);
    frameBytes[0] = 8'h3C;
    applyStimulus(1, 1'b0, 8'h00, 1 << 30);
    @(negedge clk);
    checkIdle(1);

    // Reset in the middle of the second byte of a three-byte frame.
    $display("[TB] reset mid-frame");
    frameBytes[0] = 8'h11;
    frameBytes[1] = 8'h96;
    frameBytes[2] = 8'hC3;
    applyStimulus(3, 1'b0, 8'h00, (PB + 3) * BC + 1);
    rstn    = 1'b0;
    itvalid = 1'b0;
    #1;
    checkIdle(0);
    @(negedge clk);
    rstn = 1'b1;
    frameBytes[0] = 8'h81;
    applyStimulus(1, 1'b0, 8'h00, 1 << 30);
    @(negedge clk);
    checkIdle(1);

    // 300-byte frame: byte_cnt saturates and no bit period is dropped.
    $display("[TB] 300-byte frame");
    for (int b = 0; b < 300; b++) begin
      frameBytes[b] = 8'(b) ^ 8'h5C;
    end
    applyStimulus(300, 1'b0, 8'h00, 1 << 30);
    @(negedge clk);
    checkIdle(300);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
